// File: rtl/ising_spin_readout.sv
// Host readout transmitter: snapshots spins/energy on request and streams a
// byte frame over valid/ready. Optional trailing XOR checksum: READOUT_CHECKSUM_EN.
module ising_spin_readout #(
  parameter int N_SPINS  = 32,
  parameter int ENERGY_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                snap_req_i,
  input  logic                abort_i,
  input  logic [N_SPINS-1:0]  spins_i,
  input  logic [ENERGY_W-1:0] energy_i,
  output logic [7:0]          tx_data_o,
  output logic                tx_valid_o,
  input  logic                tx_ready_i,
  output logic                busy_o,
  output logic                done_o,
  output logic [7:0]          seq_o
);

  localparam int SB    = (N_SPINS + 7) / 8;
  localparam int EB    = (ENERGY_W + 7) / 8;
  localparam int MAXB  = (SB > EB) ? SB : EB;
  localparam int IDX_W = (MAXB > 1) ? $clog2(MAXB) : 1;

  typedef enum logic [2:0] {IDLE, HDR, SEQ, SPIN, ENGY, CSUM} state_e;

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic                 frame_end;
  logic                 xfer;
  logic                 last_spin, last_engy;

  logic [N_SPINS-1:0]   snap_spins;
  logic [ENERGY_W-1:0]  snap_energy;
  logic [7:0]           snap_seq;

  logic [SB*8-1:0]      spins_pad;
  logic [EB*8-1:0]      eng_pad;
  logic [SB-1:0][7:0]   spin_bytes;
  logic [EB-1:0][7:0]   eng_bytes;

  logic [7:0]           data_d;
  logic                 valid_d, busy_d, done_d;
  logic [7:0]           seq_d;

  assign xfer      = tx_valid_o & tx_ready_i;
  assign last_spin = (idx_q == IDX_W'(SB - 1));
  assign last_engy = (idx_q == IDX_W'(EB - 1));

  // Spin bytes zero-padded on top, energy bytes sign-extended.
  always_comb begin
    spins_pad = '0;
    spins_pad[N_SPINS-1:0] = snap_spins;
  end
  assign eng_pad    = (EB*8)'($signed(snap_energy));
  assign spin_bytes = spins_pad;
  assign eng_bytes  = eng_pad;

`ifdef READOUT_CHECKSUM_EN
  logic [7:0] csum;
  always_comb begin
    csum = 8'hA5 ^ snap_seq;
    for (int i = 0; i < SB; i++) csum = csum ^ spin_bytes[i];
    for (int i = 0; i < EB; i++) csum = csum ^ eng_bytes[i];
  end
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Snapshot is taken only when a request is accepted, then frozen for the frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap_spins  <= '0;
      snap_energy <= '0;
      snap_seq    <= '0;
    end else if (state_q == IDLE && snap_req_i) begin
      snap_spins  <= spins_i;
      snap_energy <= energy_i;
      snap_seq    <= seq_o;
    end
  end

  // Next-state logic; abort wins over a coincident transfer.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    frame_end = 1'b0;
    case (state_q)
      IDLE: begin
        if (snap_req_i) begin
          state_d = HDR;
          idx_d   = '0;
        end
      end
      default: begin
        if (abort_i) begin
          state_d = IDLE;
          idx_d   = '0;
        end else if (xfer) begin
          case (state_q)
            HDR: state_d = SEQ;
            SEQ: begin
              state_d = SPIN;
              idx_d   = '0;
            end
            SPIN: begin
              if (last_spin) begin
                state_d = ENGY;
                idx_d   = '0;
              end else begin
                idx_d = idx_q + IDX_W'(1);
              end
            end
            ENGY: begin
              if (last_engy) begin
`ifdef READOUT_CHECKSUM_EN
                state_d = CSUM;
`else
                state_d   = IDLE;
                frame_end = 1'b1;
`endif
                idx_d = '0;
              end else begin
                idx_d = idx_q + IDX_W'(1);
              end
            end
`ifdef READOUT_CHECKSUM_EN
            CSUM: begin
              state_d   = IDLE;
              frame_end = 1'b1;
            end
`endif
            default: state_d = IDLE;
          endcase
        end
      end
    endcase
  end

  // Output logic: next values of the registered outputs, keyed on the next state.
  always_comb begin
    data_d  = 8'h00;
    valid_d = (state_d != IDLE);
    busy_d  = (state_d != IDLE);
    done_d  = frame_end;
    seq_d   = frame_end ? seq_o + 8'd1 : seq_o;
    case (state_d)
      HDR: data_d = 8'hA5;
      SEQ: data_d = snap_seq;
      SPIN: begin
        for (int i = 0; i < SB; i++)
          if (idx_d == IDX_W'(i)) data_d = spin_bytes[i];
      end
      ENGY: begin
        for (int i = 0; i < EB; i++)
          if (idx_d == IDX_W'(i)) data_d = eng_bytes[i];
      end
`ifdef READOUT_CHECKSUM_EN
      CSUM: data_d = csum;
`endif
      default: data_d = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_data_o  <= 8'h00;
      tx_valid_o <= 1'b0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      seq_o      <= 8'h00;
    end else begin
      tx_data_o  <= data_d;
      tx_valid_o <= valid_d;
      busy_o     <= busy_d;
      done_o     <= done_d;
      seq_o      <= seq_d;
    end
  end

endmodule
